// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster bus from the timing generator to the renderers.
// master = generator (drives), slave = text/sprite drawing blocks (samples).
interface vga_timing_gen_if;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        p_tick;
  logic        frame_tick;
  logic        blink;

  modport master (
    output hsync, vsync, video_on,
    output pixel_x, pixel_y,
    output p_tick, frame_tick, blink
  );

  modport slave (
    input hsync, vsync, video_on,
    input pixel_x, pixel_y,
    input p_tick, frame_tick, blink
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with pixel enable, frame tick, blink.
// Ports: clk, reset_n (async, low); bus (master): hsync, vsync, video_on,
// pixel_x, pixel_y, p_tick, frame_tick, blink. Macro VGA_BLINK_EN adds blink.
module vga_timing_gen #(
  parameter int CLK_DIV      = 4,
  parameter int H_DISPLAY    = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_DISPLAY    = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                clk,
  input  logic                reset_n,
  vga_timing_gen_if.master    bus
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS  = 11'(V_DISPLAY);
  localparam logic [10:0] HS_LO  = 11'(H_DISPLAY + H_FP);
  localparam logic [10:0] HS_HI  = 11'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_LO  = 11'(V_DISPLAY + V_FP);
  localparam logic [10:0] VS_HI  = 11'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DW-1:0] r_div;
  logic [10:0]   r_h;
  logic [10:0]   r_v;
  logic          r_wrap;

  logic [10:0]   r_px;
  logic [10:0]   r_py;
  logic          r_vid;
  logic          r_hs;
  logic          r_vs;
  logic          r_pt;
  logic          r_ft;

  logic w_adv;
  logic w_h_end;
  logic w_v_end;
  logic w_vid;
  logic w_hs;
  logic w_vs;

  assign w_adv   = (r_div == DIV_MAX);
  assign w_h_end = (r_h == H_MAX);
  assign w_v_end = (r_v == V_MAX);

  assign w_vid = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hs  = !((r_h >= HS_LO) && (r_h <= HS_HI));
  assign w_vs  = !((r_v >= VS_LO) && (r_v <= VS_HI));

  // r_wrap marks that the counters just wrapped to (0,0); it becomes
  // frame_tick on the edge that presents (0,0), so reset never pulses it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div  <= '0;
      r_h    <= '0;
      r_v    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_div  <= w_adv ? '0 : r_div + DW'(1);
      r_wrap <= w_adv && w_h_end && w_v_end;
      if (w_adv) begin
        if (w_h_end) begin
          r_h <= '0;
          r_v <= w_v_end ? '0 : r_v + 11'd1;
        end else begin
          r_h <= r_h + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_px  <= '0;
      r_py  <= '0;
      r_vid <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_pt  <= 1'b0;
      r_ft  <= 1'b0;
    end else begin
      r_px  <= r_h;
      r_py  <= r_v;
      r_vid <= w_vid;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_pt  <= (r_div == '0);
      r_ft  <= r_wrap;
    end
  end

  assign bus.pixel_x    = r_px;
  assign bus.pixel_y    = r_py;
  assign bus.video_on   = r_vid;
  assign bus.hsync      = r_hs;
  assign bus.vsync      = r_vs;
  assign bus.p_tick     = r_pt;
  assign bus.frame_tick = r_ft;

`ifdef VGA_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FC_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] r_fc;
  logic          r_blink;

  // Advances on r_wrap so the toggle lands on the frame_tick edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fc    <= '0;
      r_blink <= 1'b1;
    end else if (r_wrap) begin
      if (r_fc == FC_MAX) begin
        r_fc    <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_fc <= r_fc + FW'(1);
      end
    end
  end

  assign bus.blink = r_blink;
`else
  logic w_unused_bf;
  assign w_unused_bf = (BLINK_FRAMES > 0);
  assign bus.blink   = 1'b1;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench on a 14x9 raster, CLK_DIV=2.
// Expected raster derived from clk count since reset release.
module tb_vga_timing_gen;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  int k        = 0;
  int nft      = 0;
  int obs_ft   = 0;
  int first_ft = 0;
  int hs_low   = 0;
  int vs_low   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if vga();

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_DISPLAY(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISPLAY(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(vga.master)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got %0d exp %0d", tag, k, got, exp);
    end
  endtask

  task automatic check_reset(string tag);
    check({tag, "_px"}, 32'(vga.pixel_x), 0);
    check({tag, "_py"}, 32'(vga.pixel_y), 0);
    check({tag, "_vid"}, 32'(vga.video_on), 0);
    check({tag, "_hs"}, 32'(vga.hsync), 1);
    check({tag, "_vs"}, 32'(vga.vsync), 1);
    check({tag, "_pt"}, 32'(vga.p_tick), 0);
    check({tag, "_ft"}, 32'(vga.frame_tick), 0);
    check({tag, "_bl"}, 32'(vga.blink), 1);
  endtask

  // One clk: k is the number of edges since reset release.
  task automatic step();
    int n, x, y;
    logic pt, ft, vid, hs, vs, bl;
    @(posedge clk);
    @(negedge clk);
    k++;
    n   = (k - 1) / 2;
    x   = n % 14;
    y   = (n / 14) % 9;
    pt  = ((k - 1) % 2 == 0);
    ft  = pt && (k > 1) && (x == 0) && (y == 0);
    vid = (x < 8) && (y < 6);
    hs  = !(x == 10 || x == 11);
    vs  = (y != 7);
    if (ft) nft++;
`ifdef VGA_BLINK_EN
    bl = ((nft / 2) % 2 == 0);
`else
    bl = 1'b1;
`endif
    check("px", 32'(vga.pixel_x), 32'(x));
    check("py", 32'(vga.pixel_y), 32'(y));
    check("vid", 32'(vga.video_on), 32'(vid));
    check("hs", 32'(vga.hsync), 32'(hs));
    check("vs", 32'(vga.vsync), 32'(vs));
    check("pt", 32'(vga.p_tick), 32'(pt));
    check("ft", 32'(vga.frame_tick), 32'(ft));
    check("bl", 32'(vga.blink), 32'(bl));
    if (vga.frame_tick === 1'b1) begin
      obs_ft++;
      if (first_ft == 0) first_ft = k;
    end
    if (k <= 28 && vga.hsync === 1'b0) hs_low++;
    if (k <= 252 && vga.vsync === 1'b0) vs_low++;
  endtask

  task automatic restart();
    k        = 0;
    nft      = 0;
    obs_ft   = 0;
    first_ft = 0;
    hs_low   = 0;
    vs_low   = 0;
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");

    reset_n = 1'b1;
    restart();
    repeat (1265) step();
    check("hs_low_clks", 32'(hs_low), 4);
    check("vs_low_clks", 32'(vs_low), 28);
    check("first_ft_k", 32'(first_ft), 253);
    check("ft_count", 32'(obs_ft), 5);

    // Walk to the first clk of position (5,3), then reset mid-line.
    guard = 0;
    while (!((((k - 1) / 2) % 126 == 47) && ((k - 1) % 2 == 0))
           && guard < 300) begin
      step();
      guard++;
    end
    check("reach_5_3", 32'(guard < 300), 1);
    check("at_px5", 32'(vga.pixel_x), 5);
    check("at_py3", 32'(vga.pixel_y), 3);

    #1 reset_n = 1'b0;
    #1 check_reset("async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("held");

    reset_n = 1'b1;
    restart();
    repeat (260) step();
    check("rs_first_ft_k", 32'(first_ft), 253);
    check("rs_ft_count", 32'(obs_ft), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
